sv32_ptw_arbiter: RTL and testbench
===================================

// Module: sv32_ptw_arbiter
// PURPOSE
//  Shares one SV32 page-table walker between the instruction-fetch and data-access translators.
//  Each translator raises a walk request and waits for a one-cycle ready pulse carrying the leaf PTE.
//  The arbiter latches one request, drives the walker, returns the PTE to the granted requester,
//  and bounds every walk with a watchdog.
//  Sits between the translate units and the walker in the MMU of the rv32ima core.
// PARAMETERS
//  WALK_TIMEOUT  1024  max cycles walk_valid may stay high without walk_ready; 0 = watchdog disabled
// PORTS
//  clk              in   1   clock
//  resetn           in   1   asynchronous active-low reset
//  ifetch_walk_valid in  1   instruction translator requests a walk (held until ifetch_walk_ready)
//  ifetch_vaddr     in   32  virtual address for the ifetch walk
//  ifetch_walk_ready out 1   one-cycle pulse: ifetch_pte valid
//  ifetch_pte       out  32  leaf PTE returned to the ifetch translator
//  data_walk_valid  in   1   data translator requests a walk (held until data_walk_ready)
//  data_vaddr       in   32  virtual address for the data walk
//  data_walk_ready  out  1   one-cycle pulse: data_pte valid
//  data_pte         out  32  leaf PTE returned to the data translator
//  walk_valid       out  1   request to walker; held high until walk_ready
//  walk_vaddr       out  32  latched virtual address presented to the walker
//  walk_ready       in   1   walker done pulse; walk_pte valid this cycle
//  walk_pte         in   32  leaf PTE from the walker
//  busy             out  1   high in any state other than IDLE
//  walk_timeout     out  1   one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all outputs 0; pte_q=0; grant_q=IFETCH; last_grant=IFETCH; timeout count=0.
//  FSM: IDLE -> WALK -> RESP -> IDLE.
//  IDLE:
//   - If any request is valid, select the grant, latch its vaddr into walk_vaddr, go to WALK.
//   - The request is sampled in cycle 0; walk_valid rises in cycle 1 (registered).
//  WALK:
//   - walk_valid=1; the counter increments each cycle.
//   - On walk_ready: pte_q <= walk_pte, go to RESP.
//   - If WALK_TIMEOUT!=0 and the counter reaches WALK_TIMEOUT-1 without walk_ready:
//     pte_q <= 32'h0 (invalid PTE, so the translator faults), pulse walk_timeout, go to RESP.
//   - walk_ready arriving in the same cycle as the timeout: walk_ready wins, no timeout pulse.
//  RESP:
//   - Pulse the granted requester's *_walk_ready for exactly one cycle, with *_pte = pte_q.
//   - Update last_grant <= grant_q; go to IDLE.
//   - Latency: walk_ready at cycle N -> *_walk_ready at cycle N+1.
//  Ready and PTE outputs:
//   - The ungranted requester's ready stays 0.
//   - *_pte outputs are registered and hold their value until the next RESP to that requester.
//  Request handling:
//   - A requester dropping its valid mid-walk does not abort the walk; its ready still pulses.
//   - The mandatory IDLE cycle after RESP lets a translator drop valid before it can be re-granted.
//   - Requests arriving while not in IDLE wait; no queueing beyond the pending valids.
//  walk_vaddr is stable from IDLE exit until RESP exit.
//  Async reset mid-walk: immediate return to IDLE; walk_valid drops. The walker must tolerate an abandoned request.
// CONFIGURATION
//  SV32_PTW_ARB_ROUND_ROBIN_EN defined:
//   - On simultaneous requests, grant the requester != last_grant.
//   - Starvation-free: at most one walk of wait.
//  SV32_PTW_ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority; data always wins simultaneous requests.
//   - last_grant is still kept but unused.
//  Both modes grant DATA on the first contention after reset.
// STRUCTURE
//  Package sv32_ptw_arb_pkg:
//   - arb_state_t enum {IDLE, WALK, RESP}.
//   - req_idx_t enum {IFETCH=1'b0, DATA=1'b1}.
//   - localparam SV32_VADDR_W=32, SV32_PTE_W=32.
//  Sub-module sv32_ptw_arb_pick (combinational grant select):
//   - Inputs: both valids, last_grant.
//   - Outputs: grant and any_req.
//   - The macro selects its policy.
//  Top level holds the FSM, the latches and the watchdog counter ($clog2(WALK_TIMEOUT+1) bits).
// TESTING
//  Single data req (vaddr 0x4000_1234); walker returns pte 0x2000_04CF after 5 cycles
//   -> walk_valid at c1; data_walk_ready pulse 1 cycle after walk_ready; data_pte=0x2000_04CF.
//  Simultaneous ifetch+data right after reset
//   -> data granted first, then ifetch after RESP+IDLE; walk_vaddr matches each in turn.
//  RR_EN: both held valid for 4 walks -> grants D,I,D,I. Without RR_EN -> D,D,D,D, ifetch starved.
//  WALK_TIMEOUT=8, walker never responds
//   -> walk_timeout pulse at 8th WALK cycle; requester ready with pte=0; back to IDLE.
//  walk_ready coincident with the timeout cycle -> walker pte delivered; no walk_timeout pulse.
//  resetn low during WALK
//   -> walk_valid, busy, both readys go 0 asynchronously; a new request after release is granted cleanly.

Source files
------------

// File: rtl/sv32_ptw_arb_pkg.sv
// Shared types for the SV32 page-table-walker arbiter.
// Policy macro used by the slice: SV32_PTW_ARB_ROUND_ROBIN_EN.
package sv32_ptw_arb_pkg;

    localparam int unsigned SV32_VADDR_W = 32;
    localparam int unsigned SV32_PTE_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        IFETCH = 1'b0,
        DATA   = 1'b1
    } req_idx_t;

endpackage

// File: rtl/sv32_ptw_arb_pick.sv
// Combinational grant select between the ifetch and data walk requests.
// SV32_PTW_ARB_ROUND_ROBIN_EN selects round-robin; otherwise data has fixed priority.
module sv32_ptw_arb_pick
    import sv32_ptw_arb_pkg::*;
(
    input  logic     ifetch_valid,
    input  logic     data_valid,
    input  req_idx_t last_grant,
    output req_idx_t grant,
    output logic     any_req
);

    always_comb begin
        any_req = ifetch_valid | data_valid;
        grant   = IFETCH;
`ifdef SV32_PTW_ARB_ROUND_ROBIN_EN
        if (ifetch_valid && data_valid) begin
            grant = (last_grant == DATA) ? IFETCH : DATA;
        end else if (data_valid) begin
            grant = DATA;
        end
`else
        if (data_valid) begin
            grant = DATA;
        end
`endif
    end

`ifndef SV32_PTW_ARB_ROUND_ROBIN_EN
    // History is tracked in both builds but only consulted by round-robin.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/sv32_ptw_arbiter.sv
// Arbitrates one SV32 page-table walker between ifetch and data translators, with a walk watchdog.
// Grant policy set by SV32_PTW_ARB_ROUND_ROBIN_EN (undefined: data has fixed priority).
module sv32_ptw_arbiter
    import sv32_ptw_arb_pkg::*;
#(
    parameter int unsigned WALK_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ifetch_walk_valid,
    input  logic [SV32_VADDR_W-1:0] ifetch_vaddr,
    output logic                    ifetch_walk_ready,
    output logic [SV32_PTE_W-1:0]   ifetch_pte,
    input  logic                    data_walk_valid,
    input  logic [SV32_VADDR_W-1:0] data_vaddr,
    output logic                    data_walk_ready,
    output logic [SV32_PTE_W-1:0]   data_pte,
    output logic                    walk_valid,
    output logic [SV32_VADDR_W-1:0] walk_vaddr,
    input  logic                    walk_ready,
    input  logic [SV32_PTE_W-1:0]   walk_pte,
    output logic                    busy,
    output logic                    walk_timeout
);

    localparam int unsigned CNT_W = (WALK_TIMEOUT > 0) ? $clog2(WALK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WALK_TIMEOUT > 0) ? CNT_W'(WALK_TIMEOUT - 1) : '0;

    arb_state_t       state;
    req_idx_t         grant_q;
    req_idx_t         last_grant;
    req_idx_t         grant;
    logic             any_req;
    logic [CNT_W-1:0] walk_cnt;
    logic             timeout_hit;
    logic [SV32_PTE_W-1:0] resp_pte;

    sv32_ptw_arb_pick u_pick (
        .ifetch_valid (ifetch_walk_valid),
        .data_valid   (data_walk_valid),
        .last_grant   (last_grant),
        .grant        (grant),
        .any_req      (any_req)
    );

    // walk_ready takes precedence over a watchdog expiry in the same cycle.
    assign timeout_hit = (WALK_TIMEOUT != 0) && (walk_cnt == CNT_LAST) && !walk_ready;
    assign resp_pte    = walk_ready ? walk_pte : '0;

    // The per-requester PTE registers double as the latched walk result, so the
    // value seen during RESP is the one captured on WALK exit and it then holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            grant_q           <= IFETCH;
            last_grant        <= IFETCH;
            walk_cnt          <= '0;
            walk_valid        <= 1'b0;
            walk_vaddr        <= '0;
            busy              <= 1'b0;
            walk_timeout      <= 1'b0;
            ifetch_walk_ready <= 1'b0;
            ifetch_pte        <= '0;
            data_walk_ready   <= 1'b0;
            data_pte          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q    <= grant;
                        walk_vaddr <= (grant == DATA) ? data_vaddr : ifetch_vaddr;
                        walk_valid <= 1'b1;
                        busy       <= 1'b1;
                        walk_cnt   <= '0;
                        state      <= WALK;
                    end
                end
                WALK: begin
                    walk_cnt <= walk_cnt + 1'b1;
                    if (walk_ready || timeout_hit) begin
                        walk_valid   <= 1'b0;
                        walk_timeout <= timeout_hit;
                        if (grant_q == DATA) begin
                            data_walk_ready <= 1'b1;
                            data_pte        <= resp_pte;
                        end else begin
                            ifetch_walk_ready <= 1'b1;
                            ifetch_pte        <= resp_pte;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ifetch_walk_ready <= 1'b0;
                    data_walk_ready   <= 1'b0;
                    walk_timeout      <= 1'b0;
                    busy              <= 1'b0;
                    last_grant        <= grant_q;
                    state             <= IDLE;
                end
                default: begin
                    walk_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sv32_ptw_arbiter.sv
// Scoreboard bench for sv32_ptw_arbiter; grant expectations follow SV32_PTW_ARB_ROUND_ROBIN_EN.
module tb_sv32_ptw_arbiter;
    import sv32_ptw_arb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ifetch_walk_valid, data_walk_valid;
    logic [31:0] ifetch_vaddr, data_vaddr;
    logic        ifetch_walk_ready, data_walk_ready;
    logic [31:0] ifetch_pte, data_pte;
    logic        walk_valid, walk_ready, busy, walk_timeout;
    logic [31:0] walk_vaddr, walk_pte;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] pte;
        bit          to;
    } exp_t;
    exp_t exp_q[$];

    sv32_ptw_arbiter #(.WALK_TIMEOUT(8)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ifetch_walk_valid (ifetch_walk_valid),
        .ifetch_vaddr      (ifetch_vaddr),
        .ifetch_walk_ready (ifetch_walk_ready),
        .ifetch_pte        (ifetch_pte),
        .data_walk_valid   (data_walk_valid),
        .data_vaddr        (data_vaddr),
        .data_walk_ready   (data_walk_ready),
        .data_pte          (data_pte),
        .walk_valid        (walk_valid),
        .walk_vaddr        (walk_vaddr),
        .walk_ready        (walk_ready),
        .walk_pte          (walk_pte),
        .busy              (busy),
        .walk_timeout      (walk_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every ready pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (resetn) begin
            if (ifetch_walk_ready || data_walk_ready) begin
                check("ready_onehot", ifetch_walk_ready & data_walk_ready, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("grant", data_walk_ready, e.is_data);
                    check("pte", data_walk_ready ? data_pte : ifetch_pte, e.pte);
                    check("timeout_flag", walk_timeout, e.to);
                end
            end else if (walk_timeout) begin
                check("timeout_without_ready", walk_timeout, 0);
            end
        end
    end

    // Walker model: d = cycles of walk_valid before walk_ready; d = 0 never answers.
    task automatic serve(input int d, input logic [31:0] pte, input bit is_data,
                         input logic [31:0] vaddr);
        int   n;
        exp_t e;
        n = 0;
        while (!walk_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!walk_valid) begin
            check("walk_start", 0, 1);
            return;
        end
        check("walk_vaddr", walk_vaddr, vaddr);
        e.is_data = is_data;
        e.pte     = (d == 0) ? 32'h0 : pte;
        e.to      = (d == 0);
        if (d == 0) begin
            exp_q.push_back(e);
            n = 0;
            while (walk_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, 8);
        end else begin
            repeat (d - 1) @(negedge clk);
            check("vaddr_hold", walk_vaddr, vaddr);
            walk_ready = 1'b1;
            walk_pte   = pte;
            exp_q.push_back(e);
            @(negedge clk);
            walk_ready = 1'b0;
            walk_pte   = '0;
        end
        #1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("resp_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        ifetch_walk_valid = 1'b0;
        data_walk_valid   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit exp_grant [4];
        resetn = 1'b0;
        ifetch_walk_valid = 1'b0;
        data_walk_valid   = 1'b0;
        ifetch_vaddr = '0;
        data_vaddr   = '0;
        walk_ready   = 1'b0;
        walk_pte     = '0;
        repeat (2) @(negedge clk);
        check("rst_walk_valid", walk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_readys", {ifetch_walk_ready, data_walk_ready, walk_timeout}, 0);
        check("rst_ptes", ifetch_pte | data_pte | walk_vaddr, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Single data walk; walk_valid appears one cycle after the request is sampled.
        data_vaddr      = 32'h4000_1234;
        data_walk_valid = 1'b1;
        check("c0_walk_valid", walk_valid, 0);
        @(negedge clk);
        check("c1_walk_valid", walk_valid, 1);
        check("c1_busy", busy, 1);
        serve(5, 32'h2000_04CF, 1'b1, 32'h4000_1234);
        data_walk_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        check("data_pte_hold", data_pte, 32'h2000_04CF);

        // Simultaneous requests straight after reset: data first, then ifetch.
        do_reset();
        ifetch_vaddr = 32'h0001_0000;
        data_vaddr   = 32'h8000_2000;
        ifetch_walk_valid = 1'b1;
        data_walk_valid   = 1'b1;
        serve(3, 32'h1111_00CF, 1'b1, 32'h8000_2000);
        data_walk_valid = 1'b0;
        serve(2, 32'h2222_00CB, 1'b0, 32'h0001_0000);
        ifetch_walk_valid = 1'b0;
        check("data_pte_kept", data_pte, 32'h1111_00CF);

        // Both held valid for four walks.
`ifdef SV32_PTW_ARB_ROUND_ROBIN_EN
        exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        ifetch_walk_valid = 1'b1;
        data_walk_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(2 + i, 32'hA000_0000 + i, exp_grant[i],
                  exp_grant[i] ? 32'h8000_2000 : 32'h0001_0000);
        end
        ifetch_walk_valid = 1'b0;
        data_walk_valid   = 1'b0;
        repeat (2) @(negedge clk);

        // Watchdog expiry: walker never answers.
        data_vaddr      = 32'h4000_5000;
        data_walk_valid = 1'b1;
        serve(0, 32'h0, 1'b1, 32'h4000_5000);
        data_walk_valid = 1'b0;
        check("to_data_pte", data_pte, 0);
        repeat (2) @(negedge clk);

        // walk_ready on the watchdog cycle wins.
        ifetch_vaddr      = 32'h0002_3000;
        ifetch_walk_valid = 1'b1;
        serve(8, 32'h3333_00CF, 1'b0, 32'h0002_3000);
        ifetch_walk_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-walk, then a clean new grant.
        data_vaddr      = 32'h4000_7000;
        data_walk_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_walk_valid", walk_valid, 1);
        #2;
        resetn = 1'b0;
        data_walk_valid = 1'b0;
        #1;
        check("async_walk_valid", walk_valid, 0);
        check("async_busy", busy, 0);
        check("async_readys", {ifetch_walk_ready, data_walk_ready}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        ifetch_vaddr      = 32'h0004_4000;
        ifetch_walk_valid = 1'b1;
        serve(3, 32'h4444_00CF, 1'b0, 32'h0004_4000);
        ifetch_walk_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
